// File: rtl/gb80_pkg.sv
// Shared encodings for the register-pair sequencer: op codes, pair codes,
// byte register addresses and sequencer states.
package gb80_pkg;

    typedef enum logic [1:0] {
        OpLoad16 = 2'b00,
        OpRead16 = 2'b01,
        OpInc16  = 2'b10,
        OpDec16  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        PairBc      = 2'b00,
        PairDe      = 2'b01,
        PairHl      = 2'b10,
        PairIllegal = 2'b11
    } pair_e;

    localparam logic [2:0] RegB = 3'd0;
    localparam logic [2:0] RegC = 3'd1;
    localparam logic [2:0] RegD = 3'd2;
    localparam logic [2:0] RegE = 3'd3;
    localparam logic [2:0] RegH = 3'd4;
    localparam logic [2:0] RegL = 3'd5;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRdHi = 3'd1,
        StRdLo = 3'd2,
        StWrHi = 3'd3,
        StWrLo = 3'd4,
        StDone = 3'd5
    } state_e;

    function automatic logic is_adj_op(input op_e op);
        return (op == OpInc16) || (op == OpDec16);
    endfunction

endpackage

// File: rtl/regpair_sequencer.sv
// Sequences 16-bit LOAD/READ/INC/DEC operations on BC/DE/HL as byte accesses
// to an 8-bit register file. INC16/DEC16 exist only with REGPAIR_SEQ_ADJ16_EN.
module regpair_sequencer
    import gb80_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req,
    input  logic [1:0]              i_op,
    input  logic [1:0]              i_pair,
    input  logic [2*DATA_WIDTH-1:0] i_data16,
    input  logic [DATA_WIDTH-1:0]   i_rf_data,
    output logic                    o_rf_wr_en,
    output logic                    o_rf_rd_en,
    output logic [2:0]              o_rf_addr,
    output logic [DATA_WIDTH-1:0]   o_rf_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [2*DATA_WIDTH-1:0] o_data16
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    state_e          state;
    op_e             op_q;
    pair_e           pair_q;
    logic [PW-1:0]   val_q;

    op_e             req_op;
    pair_e           req_pair;
    logic            req_reject;
    logic [2:0]      req_hi_addr;
    logic [2:0]      hi_addr;
    logic [2:0]      lo_addr;
    logic [PW-1:0]   rd_word;

    assign req_op   = op_e'(i_op);
    assign req_pair = pair_e'(i_pair);

`ifdef REGPAIR_SEQ_ADJ16_EN
    logic [PW-1:0] adj_word;

    assign req_reject = (req_pair == PairIllegal);
    // Wraps naturally at the pair width; no flags are kept.
    assign adj_word   = (op_q == OpDec16) ? rd_word - PW'(1) : rd_word + PW'(1);
`else
    assign req_reject = (req_pair == PairIllegal) || is_adj_op(req_op);
`endif

    // Hi byte of the incoming request, needed on the accept edge.
    always_comb begin
        req_hi_addr = RegB;
        unique case (req_pair)
            PairBc:  req_hi_addr = RegB;
            PairDe:  req_hi_addr = RegD;
            PairHl:  req_hi_addr = RegH;
            default: req_hi_addr = RegB;
        endcase
    end

    always_comb begin
        hi_addr = RegB;
        lo_addr = RegC;
        unique case (pair_q)
            PairBc: begin
                hi_addr = RegB;
                lo_addr = RegC;
            end
            PairDe: begin
                hi_addr = RegD;
                lo_addr = RegE;
            end
            PairHl: begin
                hi_addr = RegH;
                lo_addr = RegL;
            end
            default: begin
                hi_addr = RegB;
                lo_addr = RegC;
            end
        endcase
    end

    assign rd_word = {val_q[PW-1 -: DATA_WIDTH], i_rf_data};
    assign o_busy  = (state != StIdle);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= StIdle;
            op_q       <= OpLoad16;
            pair_q     <= PairBc;
            val_q      <= '0;
            o_rf_wr_en <= 1'b0;
            o_rf_rd_en <= 1'b0;
            o_rf_addr  <= '0;
            o_rf_data  <= '0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
            o_data16   <= '0;
        end else begin
            // Strobes are single-cycle; each state re-asserts what it needs.
            o_rf_wr_en <= 1'b0;
            o_rf_rd_en <= 1'b0;
            o_rf_addr  <= '0;
            o_rf_data  <= '0;
            o_done     <= 1'b0;
            o_error    <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (i_req) begin
                        op_q   <= req_op;
                        pair_q <= req_pair;
                        if (req_reject) begin
                            state   <= StDone;
                            o_done  <= 1'b1;
                            o_error <= 1'b1;
                        end else if (req_op == OpLoad16) begin
                            val_q      <= i_data16;
                            state      <= StWrHi;
                            o_rf_wr_en <= 1'b1;
                            o_rf_addr  <= req_hi_addr;
                            o_rf_data  <= i_data16[PW-1 -: DATA_WIDTH];
                        end else begin
                            state      <= StRdHi;
                            o_rf_rd_en <= 1'b1;
                            o_rf_addr  <= req_hi_addr;
                        end
                    end
                end

                StRdHi: begin
                    val_q[PW-1 -: DATA_WIDTH] <= i_rf_data;
                    state      <= StRdLo;
                    o_rf_rd_en <= 1'b1;
                    o_rf_addr  <= lo_addr;
                end

                StRdLo: begin
`ifdef REGPAIR_SEQ_ADJ16_EN
                    if (op_q == OpRead16) begin
                        o_data16 <= rd_word;
                        state    <= StDone;
                        o_done   <= 1'b1;
                    end else begin
                        val_q      <= adj_word;
                        o_data16   <= adj_word;
                        state      <= StWrHi;
                        o_rf_wr_en <= 1'b1;
                        o_rf_addr  <= hi_addr;
                        o_rf_data  <= adj_word[PW-1 -: DATA_WIDTH];
                    end
`else
                    o_data16 <= rd_word;
                    state    <= StDone;
                    o_done   <= 1'b1;
`endif
                end

                StWrHi: begin
                    state      <= StWrLo;
                    o_rf_wr_en <= 1'b1;
                    o_rf_addr  <= lo_addr;
                    o_rf_data  <= val_q[DATA_WIDTH-1:0];
                end

                StWrLo: begin
                    state  <= StDone;
                    o_done <= 1'b1;
                end

                StDone: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regpair_sequencer.sv
// Self-checking bench for regpair_sequencer with a byte-array register file
// and a pair-level reference model. Honours REGPAIR_SEQ_ADJ16_EN.
module tb_regpair_sequencer;

    localparam int DW = 8;
`ifdef REGPAIR_SEQ_ADJ16_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  pair = '0;
    logic [15:0] d16 = '0;
    logic [7:0]  rf_rdata;
    logic        rf_wr_en, rf_rd_en, busy, done, error;
    logic [2:0]  rf_addr;
    logic [7:0]  rf_wdata;
    logic [15:0] data16;

    logic [7:0]  rf  [0:7];
    logic [7:0]  mrf [0:5];
    logic [15:0] m_d16;

    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t wq[$];

    int checks = 0;
    int errors = 0;

    regpair_sequencer #(.DATA_WIDTH(DW)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_req      (req),
        .i_op       (op),
        .i_pair     (pair),
        .i_data16   (d16),
        .i_rf_data  (rf_rdata),
        .o_rf_wr_en (rf_wr_en),
        .o_rf_rd_en (rf_rd_en),
        .o_rf_addr  (rf_addr),
        .o_rf_data  (rf_wdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error),
        .o_data16   (data16)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_addr];

    always @(posedge clk) begin
        if (rf_wr_en) begin
            rf[rf_addr] <= rf_wdata;
            wq.push_back('{a: rf_addr, d: rf_wdata});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [1:0] p, input logic [15:0] d,
                          input bit hold, input string tag);
        bit          illegal;
        int          exp_lat, lat, guard, hi, nexp;
        logic [15:0] cur, nw, exp_d16;
        illegal = (p == 2'b11) || (o[1] && !ADJ);
        exp_lat = illegal ? 1 : (o[1] ? 5 : 3);
        hi      = (p == 2'b11) ? 0 : int'(p) * 2;
        cur     = {mrf[hi], mrf[hi+1]};
        nw      = cur;
        exp_d16 = m_d16;
        nexp    = 0;
        if (!illegal) begin
            case (o)
                2'b00: nw = d;
                2'b01: exp_d16 = cur;
                2'b10: nw = cur + 16'd1;
                default: nw = cur - 16'd1;
            endcase
            if (o != 2'b01) begin
                nexp = 2;
                if (o[1]) exp_d16 = nw;
            end
        end

        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " ready"}, busy, 1'b0);

        wq.delete();
        req  = 1'b1;
        op   = o;
        pair = p;
        d16  = d;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        chk({tag, " busy"}, busy, 1'b1);
        lat = 1;
        while (!done && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        req = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " error"}, error, illegal);
        chk({tag, " data16"}, data16, exp_d16);

        chk({tag, " nwrites"}, wq.size(), nexp);
        if (wq.size() == nexp && nexp == 2) begin
            chk({tag, " wr0"}, wq[0], {3'(hi), nw[15:8]});
            chk({tag, " wr1"}, wq[1], {3'(hi + 1), nw[7:0]});
        end

        if (!illegal) begin
            mrf[hi]   = nw[15:8];
            mrf[hi+1] = nw[7:0];
        end
        m_d16 = exp_d16;
        chk({tag, " rf hi"}, rf[hi], mrf[hi]);
        chk({tag, " rf lo"}, rf[hi+1], mrf[hi+1]);

        @(posedge clk);
        #1;
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle bus"}, {done, error, rf_wr_en, rf_rd_en, rf_addr, rf_wdata}, '0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) mrf[i] = rf[i];
        m_d16 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            {busy, done, error, rf_wr_en, rf_rd_en, rf_addr, rf_wdata, data16}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 2'b01, 16'h1234, 1'b0, "load de");
        run_op(2'b00, 2'b10, 16'hABCD, 1'b0, "load hl");
        run_op(2'b01, 2'b10, 16'h0000, 1'b0, "read hl");
        run_op(2'b00, 2'b00, 16'hFFFF, 1'b0, "load bc");
        run_op(2'b10, 2'b00, 16'h0000, 1'b0, "inc bc");
        run_op(2'b00, 2'b01, 16'h0000, 1'b0, "load de0");
        run_op(2'b11, 2'b01, 16'h0000, 1'b0, "dec de");
        run_op(2'b01, 2'b01, 16'h0000, 1'b0, "read de");
        run_op(2'b01, 2'b11, 16'h5555, 1'b1, "illegal hold");
        run_op(2'b00, 2'b00, 16'h0F0F, 1'b1, "load hold");

        for (int n = 0; n < 40; n++) begin
            run_op(2'($urandom), 2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), "rand");
        end

        // Abort a LOAD in its second write cycle.
        run_op(2'b01, 2'b10, 16'h0000, 1'b0, "pre-abort read");
        @(negedge clk);
        req  = 1'b1;
        op   = 2'b00;
        pair = 2'b10;
        d16  = 16'h5678;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort in wr_lo", {rf_wr_en, rf_addr, rf_wdata}, {1'b1, 3'd5, 8'h78});
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort outputs",
            {busy, done, error, rf_wr_en, rf_rd_en, rf_addr, rf_wdata, data16}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mrf[4] = 8'h56;
        m_d16  = '0;
        chk("abort h kept", rf[4], 8'h56);
        chk("abort l kept", rf[5], mrf[5]);

        run_op(2'b01, 2'b10, 16'h0000, 1'b0, "post-abort read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
